// File: rtl/pcs_err_pkg.sv
// Shared constants for the PCS channel error injector: mode encodings and LFSR setup.
package pcs_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (register bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          REM_W     = 9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/err_span_mask.sv
// Combinational W-bit mask with bits [lo, min(W, lo+len)) set.
module err_span_mask #(
  parameter int W = 66
) (
  input  logic [6:0]   lo,
  input  logic [8:0]   len,
  output logic [W-1:0] mask
);

  logic [9:0] hi;
  assign hi = {3'b000, lo} + {1'b0, len};

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (10'(i) >= {3'b000, lo}) && (10'(i) < hi);
    end
  end

endmodule

// File: rtl/pcs_err_inject.sv
// Channel error injector: flips single bits or multi-word bursts in the parallel
// word stream and keeps saturating injection statistics.
module pcs_err_inject
  import pcs_err_pkg::*;
#(
  parameter int W     = 66,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err_req,
  input  logic [1:0]       mode,
  input  logic [7:0]       burst_len,
  input  logic             fix_pos_en,
  input  logic [6:0]       fix_pos,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [W-1:0]     out_mask,
  output logic             busy,
  output logic [CNT_W-1:0] inj_cnt,
  output logic [CNT_W-1:0] flip_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int PC_W = $clog2(W + 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W + 1)'(b);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] m);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + PC_W'(m[i]);
    return c;
  endfunction

  logic [15:0]      lfsr;
  logic [REM_W-1:0] rem, rem_d, take, end_pos, rem_new, span_len, len_eff;
  logic [6:0]       p, s, span_lo;
  logic             abort, cont, start, drop;
  logic [W-1:0]     span, mask_p0;

  logic             vld_p1, busy_p1;
  logic [W-1:0]     data_p1, mask_p1;

  assign p = (lfsr[6:0] >= 7'(W)) ? lfsr[6:0] - 7'(W) : lfsr[6:0];
  assign s = fix_pos_en ? fix_pos : p;

  always_comb begin
    case (mode_e'(mode))
      MODE_SINGLE: len_eff = 9'd1;
      MODE_BURST:  len_eff = {1'b0, burst_len};
      default:     len_eff = '0;
    endcase
  end

  // Reserved mode shares the "off" behaviour, including aborting a pending burst.
  assign abort = (mode_e'(mode) == MODE_OFF) || (mode_e'(mode) == MODE_RSVD);
  assign cont  = in_valid && !abort && (rem != '0);
  assign start = in_valid && !abort && (rem == '0) && err_req && (len_eff != '0);
  assign drop  = cont && err_req;

  assign take    = (rem > REM_W'(W)) ? REM_W'(W) : rem;
  assign end_pos = {2'b00, s} + len_eff;
  assign rem_new = (end_pos > REM_W'(W)) ? end_pos - REM_W'(W) : '0;

  assign span_lo  = cont ? 7'd0 : s;
  assign span_len = cont ? rem : len_eff;

  err_span_mask #(.W(W)) u_span (
    .lo   (span_lo),
    .len  (span_len),
    .mask (span)
  );

  assign mask_p0 = (cont || start) ? span : '0;

  always_comb begin
    rem_d = rem;
    if (in_valid) begin
      if (abort)      rem_d = '0;
      else if (cont)  rem_d = rem - take;
      else if (start) rem_d = rem_new;
    end
  end

  // Stage p0 -> p1: register output word, mask, burst state and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      rem      <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      mask_p1  <= '0;
      busy_p1  <= 1'b0;
      inj_cnt  <= '0;
      flip_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      vld_p1  <= in_valid;
      mask_p1 <= mask_p0;
      rem     <= rem_d;
      busy_p1 <= (rem_d != '0);
      if (in_valid) begin
        lfsr     <= lfsr_next(lfsr);
        data_p1  <= in_data ^ mask_p0;
        flip_cnt <= sat_add(flip_cnt, popcount(mask_p0));
      end
      if (start) inj_cnt  <= sat_add(inj_cnt, PC_W'(1));
      if (drop)  drop_cnt <= sat_add(drop_cnt, PC_W'(1));
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_mask  = mask_p1;
  assign busy      = busy_p1;

endmodule

// File: tb/tb_pcs_err_inject.sv
// Directed-vector bench for pcs_err_inject with hand-computed expected values.
module tb_pcs_err_inject;

  localparam int W     = 66;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             err_req;
  logic [1:0]       mode;
  logic [7:0]       burst_len;
  logic             fix_pos_en;
  logic [6:0]       fix_pos;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [W-1:0]     out_mask;
  logic             busy;
  logic [CNT_W-1:0] inj_cnt, flip_cnt, drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] ALL66 = (128'h1 << 66) - 128'h1;

  pcs_err_inject #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .err_req    (err_req),
    .mode       (mode),
    .burst_len  (burst_len),
    .fix_pos_en (fix_pos_en),
    .fix_pos    (fix_pos),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .busy       (busy),
    .inj_cnt    (inj_cnt),
    .flip_cnt   (flip_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    logic [15:0]  l;
    logic [6:0]   ep;
    logic [127:0] first_mask, second_mask;
    int           bad;

    rst = 1'b1; err_req = 0; mode = 0; burst_len = 0; fix_pos_en = 1; fix_pos = 0;
    in_valid = 0; in_data = '0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_mask",  out_mask, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_cnts",  {inj_cnt, flip_cnt, drop_cnt}, 0);
    rst = 1'b0;

    // single-bit flip at position 5
    mode = 1; fix_pos = 5; err_req = 1; in_valid = 1; in_data = '0;
    step();
    chk("single_data",  out_data, 128'h20);
    chk("single_valid", out_valid, 1);
    chk("single_inj",   inj_cnt, 1);
    chk("single_flip",  flip_cnt, 1);
    err_req = 0; in_valid = 0;
    step();
    chk("idle_mask",  out_mask, 0);
    chk("idle_hold",  out_data, 128'h20);
    chk("idle_valid", out_valid, 0);

    // wrapping burst of 10 from bit 60
    do_reset();
    mode = 2; burst_len = 10; fix_pos = 60; err_req = 1; in_valid = 1; in_data = '0;
    step();
    chk("wrap_w1_mask", out_mask, 128'h3F << 60);
    chk("wrap_w1_busy", busy, 1);
    err_req = 0;
    step();
    chk("wrap_w2_mask", out_mask, 128'hF);
    chk("wrap_w2_busy", busy, 0);
    chk("wrap_flip",    flip_cnt, 10);
    chk("wrap_inj",     inj_cnt, 1);

    // drop while busy: 200-bit burst from bit 0
    do_reset();
    mode = 2; burst_len = 200; fix_pos = 0; err_req = 1; in_valid = 1;
    step();
    chk("drop_w1_mask", out_mask, ALL66);
    step();
    chk("drop_w2_mask", out_mask, ALL66);
    step();
    chk("drop_w3_busy", busy, 1);
    err_req = 0;
    step();
    chk("drop_w4_mask", out_mask, 128'h3);
    chk("drop_w4_busy", busy, 0);
    chk("drop_cnt",     drop_cnt, 2);
    chk("drop_inj",     inj_cnt, 1);
    chk("drop_flip",    flip_cnt, 200);

    // gaps between burst words
    do_reset();
    mode = 2; burst_len = 10; fix_pos = 60; err_req = 1; in_valid = 1; in_data = '0;
    step();
    err_req = 0; in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_mask", out_mask, 0);
      chk("gap_busy", busy, 1);
      chk("gap_hold", out_data, 128'h3F << 60);
    end
    in_valid = 1; in_data = 66'h5A5A;
    step();
    chk("gap_cont_data", out_data, 128'h5A55);
    chk("gap_cont_busy", busy, 0);

    // abort with mode 0 mid-burst
    do_reset();
    mode = 2; burst_len = 200; fix_pos = 0; err_req = 1; in_valid = 1; in_data = '0;
    step();
    mode = 0; err_req = 0; in_data = 66'h1234;
    step();
    chk("abort_mask", out_mask, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", out_data, 128'h1234);
    mode = 2; in_data = '0;
    step();
    chk("abort_after_mask", out_mask, 0);
    chk("abort_flip",       flip_cnt, 66);

    // mode 2 -> 1 change keeps pending continuation
    do_reset();
    mode = 2; burst_len = 100; fix_pos = 0; err_req = 1;
    step();
    mode = 1; err_req = 0;
    step();
    chk("modechg_mask", out_mask, (128'h1 << 34) - 128'h1);
    chk("modechg_flip", flip_cnt, 100);

    // zero-length and reserved-mode requests do nothing
    do_reset();
    mode = 2; burst_len = 0; err_req = 1;
    step();
    mode = 3; burst_len = 8;
    step();
    chk("zero_len_mask", out_mask, 0);
    chk("zero_len_cnts", {inj_cnt, flip_cnt, drop_cnt}, 0);

    // asynchronous reset mid-burst, then a fresh event
    do_reset();
    mode = 2; burst_len = 200; fix_pos = 0; err_req = 1;
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_outs", {out_valid, busy, out_mask, out_data}, 0);
    chk("rstmid_cnts", {inj_cnt, flip_cnt, drop_cnt}, 0);
    rst = 1'b0;
    mode = 1; fix_pos = 3;
    step();
    chk("rstmid_new_mask", out_mask, 128'h8);
    chk("rstmid_new_inj",  inj_cnt, 1);

    // LFSR positions and counter saturation
    do_reset();
    mode = 1; fix_pos_en = 0; err_req = 1; in_valid = 1; in_data = '0;
    l = 16'hACE1;
    bad = 0;
    first_mask = '0;
    second_mask = '0;
    for (int i = 0; i < 70000; i++) begin
      ep = (l[6:0] >= 7'd66) ? l[6:0] - 7'd66 : l[6:0];
      step();
      if (i == 0) first_mask = out_mask;
      if (i == 1) second_mask = out_mask;
      if (out_mask !== (66'h1 << ep)) bad++;
      l = lfsr_step(l);
    end
    chk("lfsr_first",  first_mask, 128'h1 << 31);
    chk("lfsr_second", second_mask, 128'h2);
    chk("lfsr_pos_errs", bad, 0);
    chk("sat_inj",  inj_cnt, 16'hFFFF);
    chk("sat_flip", flip_cnt, 16'hFFFF);
    chk("sat_drop", drop_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
